// File: rtl/deck_shuffler.sv
// deck_shuffler: builds a shoe of NUM_DECKS x DECK_SIZE cards, permutes it with a
// rejection-sampled Fisher-Yates pass driven by a Galois LFSR, then deals one card
// per valid/ready handshake. Reshuffle on request; reports cards left.
module deck_shuffler #(
    parameter int                DECK_SIZE = 52,
    parameter int                NUM_DECKS = 1,
    parameter int                CARD_W    = 6,
    parameter int                IDX_W     = 9,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shuffle_req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              busy,
    output logic              card_valid,
    input  logic              card_ready,
    output logic [CARD_W-1:0] card,
    output logic [IDX_W-1:0]  cards_left,
    output logic              shoe_empty
);

    localparam int               SHOE      = DECK_SIZE * NUM_DECKS;
    // Address width of the shoe storage (exactly enough bits for 0..SHOE-1)
    localparam int               AW        = $clog2(SHOE);
    localparam logic [IDX_W-1:0] SHOE_N    = IDX_W'(SHOE);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SHOE - 1);
    localparam logic [CARD_W-1:0] LAST_VAL = CARD_W'(DECK_SIZE - 1);
    localparam logic [AW-1:0]    LAST_AW   = AW'(SHOE - 1);

    // DRAW and SWAP together form one Fisher-Yates step; busy covers INIT..SWAP
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DRAW,
        S_SWAP,
        S_DEAL
    } state_t;

    state_t              state_q;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_step;
    logic [IDX_W-1:0]    idx_q;      // k during INIT, i during shuffle
    logic [CARD_W-1:0]   val_q;      // k mod DECK_SIZE, kept as a wrapping counter
    logic [AW-1:0]       j_q;        // accepted swap partner
    logic [IDX_W-1:0]    ptr_q;      // next card to deal
    logic                busy_q, valid_q, empty_q;
    logic [IDX_W-1:0]    left_q;
    logic [CARD_W-1:0]   shoe_q [SHOE];

    logic [IDX_W-1:0]    draw_mask, draw_r;
    logic                draw_ok, xfer;
    logic [AW-1:0]       rd_idx;

    // All ones from bit 0 up to the highest set bit of v
    function automatic logic [IDX_W-1:0] msb_mask(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] m;
        m = v;
        for (int s = 1; s < IDX_W; s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

    // LFSR next state: Galois right shift, seed_load takes priority, zero seed replaced
    always_comb begin
        lfsr_step = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        if (seed_load) begin
            lfsr_d = (seed_in == '0) ? SEED : seed_in;
        end else begin
            lfsr_d = lfsr_step;
        end
    end

    // LFSR register advances every cycle outside reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    // Candidate swap index; values above i are rejected to keep the draw unbiased
    always_comb begin
        draw_mask = msb_mask(idx_q);
        draw_r    = lfsr_q[IDX_W-1:0] & draw_mask;
        draw_ok   = (draw_r <= idx_q);
        xfer      = valid_q & card_ready;
    end

    // Control FSM with registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            val_q   <= '0;
            j_q     <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            left_q  <= '0;
            empty_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (shuffle_req) begin
                        state_q <= S_INIT;
                        idx_q   <= '0;
                        val_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_INIT: begin
                    val_q <= (val_q == LAST_VAL) ? '0 : val_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DRAW;   // idx_q already holds SHOE-1
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DRAW: begin
                    if (draw_ok) begin
                        j_q     <= draw_r[AW-1:0];
                        state_q <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    idx_q <= idx_q - 1'b1;
                    if (idx_q == IDX_W'(1)) begin
                        state_q <= S_DEAL;
                        ptr_q   <= '0;
                        left_q  <= SHOE_N;
                        valid_q <= 1'b1;
                        empty_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_DRAW;
                    end
                end
                S_DEAL: begin
                    // A reshuffle request beats a same-cycle transfer
                    if (shuffle_req) begin
                        state_q <= S_INIT;
                        idx_q   <= '0;
                        val_q   <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        left_q  <= '0;
                        empty_q <= 1'b1;
                    end else if (xfer) begin
                        ptr_q  <= ptr_q + 1'b1;
                        left_q <= left_q - 1'b1;
                        if (left_q == IDX_W'(1)) begin
                            valid_q <= 1'b0;
                            empty_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Shoe storage: sequential fill in INIT, element exchange in SWAP (j == i is harmless)
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            shoe_q[idx_q[AW-1:0]] <= val_q;
        end else if (state_q == S_SWAP) begin
            shoe_q[idx_q[AW-1:0]] <= shoe_q[j_q];
            shoe_q[j_q]           <= shoe_q[idx_q[AW-1:0]];
        end
    end

    // Top card read; once the shoe is drained the last dealt card stays visible
    always_comb begin
        rd_idx = (ptr_q == SHOE_N) ? LAST_AW : ptr_q[AW-1:0];
        card   = (state_q == S_DEAL) ? shoe_q[rd_idx] : '0;
    end

    assign busy       = busy_q;
    assign card_valid = valid_q;
    assign cards_left = left_q;
    assign shoe_empty = empty_q;

endmodule

// File: tb/tb_deck_shuffler.sv
// Scoreboard bench for deck_shuffler: the stimulus side computes each expected shoe
// from the shuffle rules and queues it; a negedge monitor pops on every transfer.
module tb_deck_shuffler;

    localparam int DS    = 52;
    localparam int SHOE  = 52;
    localparam int IDX_W = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        shuffle_req, seed_load, card_ready;
    logic [15:0] seed_in;
    logic        busy, card_valid, shoe_empty;
    logic [5:0]  card;
    logic [8:0]  cards_left;

    logic        shuffle_req2, seed_load2, card_ready2;
    logic [15:0] seed_in2;
    logic        busy2, card_valid2, shoe_empty2;
    logic [5:0]  card2;
    logic [8:0]  cards_left2;

    int          errors = 0;
    int          checks = 0;
    int          exp_q[$];
    int          dealt_q[$];
    logic [15:0] m_lfsr;
    int          last_card;
    bit          stall;
    int          stall_card;

    deck_shuffler u_dut (
        .clk(clk), .rst(rst), .shuffle_req(shuffle_req), .seed_load(seed_load),
        .seed_in(seed_in), .busy(busy), .card_valid(card_valid), .card_ready(card_ready),
        .card(card), .cards_left(cards_left), .shoe_empty(shoe_empty)
    );

    deck_shuffler #(.NUM_DECKS(2)) u_dut2 (
        .clk(clk), .rst(rst), .shuffle_req(shuffle_req2), .seed_load(seed_load2),
        .seed_in(seed_in2), .busy(busy2), .card_valid(card_valid2), .card_ready(card_ready2),
        .card(card2), .cards_left(cards_left2), .shoe_empty(shoe_empty2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] adv(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Reference LFSR value for the current cycle
    always @(posedge clk or posedge rst) begin
        if (rst)            m_lfsr <= 16'hACE1;
        else if (seed_load) m_lfsr <= (seed_in == 16'h0) ? 16'hACE1 : seed_in;
        else                m_lfsr <= adv(m_lfsr);
    end

    // Fisher-Yates reference: l0 is the LFSR value in the cycle the request is sampled.
    // Returns the busy length and queues the expected deal order.
    task automatic model_shuffle(input logic [15:0] l0, output int bcyc);
        int          deck[SHOE];
        logic [15:0] l;
        int          r, m, tmp;
        bit          done;
        for (int k = 0; k < SHOE; k++) deck[k] = k % DS;
        l = l0;
        for (int k = 0; k <= SHOE; k++) l = adv(l);
        bcyc = SHOE;
        for (int i = SHOE - 1; i >= 1; i--) begin
            m    = (1 << $clog2(i + 1)) - 1;
            done = 1'b0;
            r    = 0;
            while (!done) begin
                r = int'(l[IDX_W-1:0]) & m;
                bcyc++;
                if (r <= i) done = 1'b1;
                else        l = adv(l);
            end
            tmp = deck[i]; deck[i] = deck[r]; deck[r] = tmp;
            bcyc++;
            l = adv(adv(l));
        end
        exp_q.delete();
        for (int k = 0; k < SHOE; k++) exp_q.push_back(deck[k]);
    endtask

    // Monitor: pops the scoreboard on each accepted card, checks hold under backpressure
    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall && card_valid) chk("card_stable", card, stall_card);
            if (card_valid && card_ready && !shuffle_req) begin
                if (exp_q.size() == 0) begin
                    chk("extra_card", 1, 0);
                end else begin
                    chk("card", card, exp_q.pop_front());
                    chk("cards_left", cards_left, exp_q.size() + 1);
                    chk("not_empty", shoe_empty, 0);
                end
                last_card = card;
                dealt_q.push_back(card);
            end
            stall      = card_valid && !card_ready && !shuffle_req;
            stall_card = card;
        end
    end

    task automatic start_shuffle(output int bcyc);
        model_shuffle(m_lfsr, bcyc);
        shuffle_req = 1'b1;
        @(posedge clk); #1;
        shuffle_req = 1'b0;
    endtask

    task automatic wait_deal(input int bcyc);
        int n = 1;
        chk("busy_after_req", busy, 1);
        while (busy && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_cycles", n - 1, bcyc);
        chk("valid_at_deal", card_valid, 1);
        chk("left_at_deal", cards_left, SHOE);
    endtask

    task automatic deal_until(input int target, input bit rnd);
        int n = 0;
        while (exp_q.size() > target && n < 2000) begin
            card_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        card_ready = 1'b0;
        chk("deal_in_time", int'(n < 2000), 1);
    endtask

    task automatic check_empty();
        chk("empty_flag", shoe_empty, 1);
        chk("empty_valid", card_valid, 0);
        chk("empty_left", cards_left, 0);
        chk("card_holds_last", card, last_card);
    endtask

    task automatic check_hist();
        int h[64];
        int bad = 0;
        foreach (h[v]) h[v] = 0;
        foreach (dealt_q[k]) h[dealt_q[k] & 63]++;
        for (int v = 0; v < DS; v++) if (h[v] != 1) bad++;
        chk("deal_count", dealt_q.size(), SHOE);
        chk("each_value_once", bad, 0);
    endtask

    task automatic run_seeded(input logic [15:0] s, output int seq[$]);
        int b;
        dealt_q.delete();
        seed_in   = s;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        start_shuffle(b);
        wait_deal(b);
        deal_until(0, 1'b1);
        seq = dealt_q;
    endtask

    task automatic cmp_seq(input string nm, input int a[$], input int b[$]);
        int diff = 0;
        if (a.size() != b.size()) diff = 1000;
        else foreach (a[k]) if (a[k] != b[k]) diff++;
        chk(nm, diff, 0);
    endtask

    initial begin
        int b;
        int seq_a[$], seq_b[$], seq_c[$], seq_d[$];
        int hist2[64];
        int got, n, bad;

        shuffle_req = 0; seed_load = 0; seed_in = 0; card_ready = 0;
        shuffle_req2 = 0; seed_load2 = 0; seed_in2 = 0; card_ready2 = 0;
        last_card = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", card_valid, 0);
        chk("rst_left", cards_left, 0);
        chk("rst_empty", shoe_empty, 1);
        chk("rst_card", card, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // Plain deal at full throughput
        dealt_q.delete();
        start_shuffle(b);
        wait_deal(b);
        deal_until(0, 1'b0);
        check_empty();
        check_hist();

        // Ready on an empty shoe does nothing
        card_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("empty_ready_left", cards_left, 0);
        chk("empty_ready_valid", card_valid, 0);
        card_ready = 1'b0;

        // Random backpressure
        dealt_q.delete();
        start_shuffle(b);
        wait_deal(b);
        deal_until(0, 1'b1);
        check_empty();
        check_hist();

        // Determinism and zero-seed fallback
        run_seeded(16'h1234, seq_a);
        run_seeded(16'h1234, seq_b);
        cmp_seq("seed_repeat", seq_a, seq_b);
        run_seeded(16'h0000, seq_c);
        run_seeded(16'hACE1, seq_d);
        cmp_seq("zero_seed", seq_c, seq_d);

        // Reshuffle mid-deal beats a same-cycle transfer
        start_shuffle(b);
        wait_deal(b);
        deal_until(42, 1'b0);
        chk("left_before_abort", cards_left, 42);
        card_ready = 1'b1;
        start_shuffle(b);
        card_ready = 1'b0;
        chk("abort_valid", card_valid, 0);
        wait_deal(b);
        deal_until(0, 1'b0);
        check_empty();

        // Reset in the middle of the shuffle
        start_shuffle(b);
        repeat (SHOE + 10) @(posedge clk); #1;
        chk("mid_shuffle_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", card_valid, 0);
        chk("mrst_left", cards_left, 0);
        chk("mrst_empty", shoe_empty, 1);
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-deck shoe
        shuffle_req2 = 1'b1;
        @(posedge clk); #1;
        shuffle_req2 = 1'b0;
        card_ready2  = 1'b1;
        foreach (hist2[v]) hist2[v] = 0;
        got = 0;
        n   = 0;
        while (got < 2 * SHOE && n < 6000) begin
            if (card_valid2) begin
                chk("left2", cards_left2, 2 * SHOE - got);
                hist2[card2]++;
                got++;
            end
            @(posedge clk); #1;
            n++;
        end
        card_ready2 = 1'b0;
        bad = 0;
        for (int v = 0; v < DS; v++) if (hist2[v] != 2) bad++;
        chk("dut2_count", got, 2 * SHOE);
        chk("dut2_each_twice", bad, 0);
        chk("dut2_empty", shoe_empty2, 1);
        chk("dut2_valid", card_valid2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
